// File: rtl/reg_i8_i8b_pkg.sv
// Shared types and defaults for the reg_i8_i8b enabled data register.
// Optional parity output is controlled by REG_I8_I8B_PARITY_EN (see reg_i8_i8b.sv).
package reg_i8_i8b_pkg;

    localparam int               WIDTH = 8;
    localparam logic [WIDTH-1:0] INIT  = 8'd3;

    typedef logic [WIDTH-1:0] data_t;

    // Odd parity of a data word: 1 when it holds an odd number of set bits.
    function automatic logic odd_parity(input data_t v);
        return ^v;
    endfunction

endpackage

// File: rtl/reg_i8_i8b_en_dff.sv
// Generic WIDTH-bit flop with load enable and an asynchronous active-low reset
// that forces a parameterised reset value.
module en_dff #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_i8_i8b.sv
// Enabled i8 -> i8 storage register with non-zero reset value; y comes straight
// from the flop. Define REG_I8_I8B_PARITY_EN to add a registered y_par output.
module reg_i8_i8b
    import reg_i8_i8b_pkg::*;
#(
    parameter int               WIDTH = reg_i8_i8b_pkg::WIDTH,
    parameter logic [WIDTH-1:0] INIT  = reg_i8_i8b_pkg::INIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic [WIDTH-1:0] y
`ifdef REG_I8_I8B_PARITY_EN
    ,
    output logic             y_par
`endif
);

    en_dff #(
        .WIDTH   (WIDTH),
        .RST_VAL (INIT)
    ) u_q (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .d     (a),
        .q     (y)
    );

`ifdef REG_I8_I8B_PARITY_EN
    logic w_a_par;

    // Parity is computed from the incoming word so it lands on the same edge as y.
    assign w_a_par = ^a;

    en_dff #(
        .WIDTH   (1),
        .RST_VAL (^INIT)
    ) u_par (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .d     (w_a_par),
        .q     (y_par)
    );
`endif

endmodule

// File: tb/tb_reg_i8_i8b.sv
// Self-checking bench for reg_i8_i8b: directed scenarios plus randomized
// load/hold/reset traffic against a simple behavioural register model.
module tb_reg_i8_i8b;

    localparam logic [7:0] INIT_VAL = 8'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a     = 8'd0;
    logic       en    = 1'b0;
    logic [7:0] y;
`ifdef REG_I8_I8B_PARITY_EN
    logic       y_par;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q;

    reg_i8_i8b dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .en    (en),
        .y     (y)
`ifdef REG_I8_I8B_PARITY_EN
        ,
        .y_par (y_par)
`endif
    );

    always #5 clock = ~clock;

    // Model parity by counting bits rather than XOR-reducing.
    function automatic logic model_par(input logic [7:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    // One clock cycle: model reacts to the rising edge, bench returns at the falling edge.
    task automatic tick();
        @(posedge clock);
        if (reset === 1'b1 && en === 1'b1) exp_q = a;
        @(negedge clock);
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b0;
        a     = 8'd9;
        en    = 1'b1;
        exp_q = INIT_VAL;
        #1;
        n_cmp++;
        if (y !== INIT_VAL) begin
            n_err++;
            $display("FAIL reset_async_entry y=%h expected=%h", y, INIT_VAL);
        end
        @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if (y !== INIT_VAL) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d y=%h expected=%h", i, y, INIT_VAL);
            end
`ifdef REG_I8_I8B_PARITY_EN
            n_cmp++;
            if (y_par !== model_par(INIT_VAL)) begin
                n_err++;
                $display("FAIL reset_par cyc=%0d y_par=%b expected=%b", i, y_par, model_par(INIT_VAL));
            end
`endif
        end
    endtask

    task automatic test_release();
        reset = 1'b1;
        a     = 8'd9;
        en    = 1'b1;
        #1;
        n_cmp++;
        if (y !== INIT_VAL) begin
            n_err++;
            $display("FAIL release_no_change y=%h expected=%h", y, INIT_VAL);
        end
        tick();
        n_cmp++;
        if (y !== 8'd9) begin
            n_err++;
            $display("FAIL release_first_load y=%h expected=09", y);
        end
    endtask

    task automatic test_hold();
        en = 1'b0;
        a  = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (y !== 8'd9) begin
                n_err++;
                $display("FAIL hold cyc=%0d y=%h expected=09", i, y);
            end
        end
    endtask

    task automatic test_patterns();
        logic [7:0] pats [4];
        logic       pars [4];
        pats = '{8'h00, 8'hFF, 8'h80, 8'h7F};
        pars = '{1'b0, 1'b0, 1'b1, 1'b1};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = pats[i];
            tick();
            n_cmp++;
            if (y !== pats[i]) begin
                n_err++;
                $display("FAIL pattern idx=%0d y=%h expected=%h", i, y, pats[i]);
            end
`ifdef REG_I8_I8B_PARITY_EN
            n_cmp++;
            if (y_par !== pars[i]) begin
                n_err++;
                $display("FAIL pattern_par idx=%0d y_par=%b expected=%b", i, y_par, pars[i]);
            end
`else
            if (pars[i] !== model_par(pats[i])) $display("note: parity table entry %0d inconsistent", i);
`endif
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        a  = 8'hAA;
        tick();
        n_cmp++;
        if (y !== 8'hAA) begin
            n_err++;
            $display("FAIL async_preload y=%h expected=aa", y);
        end
        #2;
        reset = 1'b0;
        exp_q = INIT_VAL;
        #1;
        n_cmp++;
        if (y !== INIT_VAL) begin
            n_err++;
            $display("FAIL async_immediate y=%h expected=%h", y, INIT_VAL);
        end
        // A load requested while reset is held must be discarded.
        a  = 8'h55;
        en = 1'b1;
        @(negedge clock);
        tick();
        n_cmp++;
        if (y !== INIT_VAL) begin
            n_err++;
            $display("FAIL async_pending_discard y=%h expected=%h", y, INIT_VAL);
        end
        reset = 1'b1;
        en    = 1'b0;
        a     = 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (y !== INIT_VAL) begin
                n_err++;
                $display("FAIL async_release_hold cyc=%0d y=%h expected=%h", i, y, INIT_VAL);
            end
        end
    endtask

    task automatic test_toggle_en();
        logic [7:0] base;
        base = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            a  = base + 8'(i);
            en = (i % 2 == 0);
            tick();
            n_cmp++;
            if (y !== exp_q) begin
                n_err++;
                $display("FAIL toggle_en cyc=%0d en=%b y=%h expected=%h", i, en, y, exp_q);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            a  = 8'($urandom);
            en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                #2;
                reset = 1'b0;
                exp_q = INIT_VAL;
                #1;
                n_cmp++;
                if (y !== exp_q) begin
                    n_err++;
                    $display("FAIL random_reset cyc=%0d y=%h expected=%h", i, y, exp_q);
                end
                @(negedge clock);
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
            n_cmp++;
            if (y !== exp_q) begin
                n_err++;
                $display("FAIL random cyc=%0d en=%b y=%h expected=%h", i, en, y, exp_q);
            end
`ifdef REG_I8_I8B_PARITY_EN
            n_cmp++;
            if (y_par !== model_par(exp_q)) begin
                n_err++;
                $display("FAIL random_par cyc=%0d y_par=%b expected=%b", i, y_par, model_par(exp_q));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_hold();
        test_patterns();
        test_async_reset();
        test_toggle_en();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_i8_i8b.md
Name: reg_i8_i8b

Overview:
- Single 8-bit data register with load enable and a non-zero reset value (3).
- Sequential leaf element used wherever the datapath needs an enabled i8 -> i8 pipeline/storage register.
- Output is driven directly from the flop; there is no combinational path from `a` or `en` to `y`.

Parameters:
- WIDTH, 8, data width of `a` and `y`.
- INIT, 8'd3, value loaded into the register while reset is asserted; WIDTH bits wide.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted; assertion takes effect immediately, independent of clock.
- a  input  WIDTH  data to load.
- en  input  1  load enable, active-high.
- y  output  WIDTH  registered value.

Behaviour:
- State: one WIDTH-bit register `q`; `y` = `q` at all times.
- Reset asserted (reset=0):
  - `q` takes INIT asynchronously, without waiting for a clock edge.
  - `q` stays at INIT for as long as reset is held, regardless of `a`, `en` or clock activity.
- Reset release (0->1): no state change at the moment of release. The first rising clock edge with reset=1 is the first edge that may update `q`.
- Normal operation (reset=1), at each rising clock edge:
  - en=1: `q` <= `a`.
  - en=0: `q` holds its value.
- Latency: one cycle from `a`/`en` sampled at an edge to `y` changing. `y` shows the old value up to that edge and the new value after it.
- en is evaluated every cycle; there is no handshake or back-pressure.
- Simultaneous events:
  - Reset asserted at or during a clock edge: reset wins and `q` = INIT.
  - Reset asserted mid-operation: any pending load is discarded; `y` = INIT until the first edge after release.
- Width rules: no arithmetic and no truncation/extension; `a` and `y` are both WIDTH bits.
- X handling: `en`=X when reset=1 is illegal; implementation may propagate X.

Optional Feature:
- Macro: REG_I8_I8B_PARITY_EN.
- Defined:
  - Adds output port `y_par` (1 bit) = XOR-reduction of `q`, i.e. `y_par`=1 when `q` has an odd number of 1 bits.
  - `y_par` is registered alongside `q` on the same edge, so it is always consistent with `y`.
  - Reset value = XOR-reduction of INIT (INIT=3 gives 0).
- Undefined: the `y_par` port and its logic are absent. Port list and behaviour are exactly as above.

Decomposition:
- Shared package `reg_i8_i8b_pkg`: WIDTH default (8), INIT default (8'd3), data typedef `data_t` = logic [WIDTH-1:0].
- One natural sub-module: `en_dff`, a generic WIDTH-bit async-active-low-reset flop with enable and a reset-value parameter.
  - Instantiated once for `q`.
  - Instantiated a second time at width 1 for `y_par` when REG_I8_I8B_PARITY_EN is defined.

Test Plan:
- Hold reset=0 for 16 cycles with a=9, en=1 -> `y`=3 on every cycle; no load occurs.
- Release reset at a falling edge with a=9, en=1 -> `y`=3 just before the first rising edge, then `y`=9 after it.
- After `y`=9, drive en=0 with a=0 for two or more edges -> `y` stays 9.
- With en=1, apply a = 0x00, 0xFF, 0x80, 0x7F on successive edges -> `y` follows each value one cycle later. With REG_I8_I8B_PARITY_EN defined: `y_par` = 0, 0, 1, 1 respectively.
- With `y`=0xAA, assert reset=0 between clock edges -> `y`=3 immediately without a clock edge. After release with en=0, `y` stays 3.
- Toggle en every cycle while a increments by 1 each cycle -> `y` updates only on edges where en=1 and holds otherwise.
